svm_pe_ctrl: RTL and testbench
==============================

SVM_PE_CTRL -- requirements
Module: svm_pe_ctrl

Interface
REQ-001 The block SHALL have parameter FEA_I, default 4, meaning integer bits of the Q-format (two's complement) datapath.
REQ-002 The block SHALL have parameter FEA_F, default 28, meaning fractional bits; W = FEA_I+FEA_F.
REQ-003 The block SHALL have parameter NBLK, default 105, meaning HOG blocks per detection window.
REQ-004 The block SHALL have parameter PE_LAT, default 3, meaning cycles from o_pe_valid to a valid i_pe_data (PE_LAT >= 1).
REQ-005 The block SHALL have parameter AW, default $clog2(NBLK), meaning coefficient address width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 i_start  in  1  one-cycle pulse that begins a window.
REQ-009 i_abort  in  1  synchronous abort of the current window.
REQ-010 i_fea_valid  in  1  feature block offered.
REQ-011 o_fea_ready  out  1  controller can accept a feature block.
REQ-012 i_fea  in  36*W  four cells x 9 bins, cell a in the LSBs.
REQ-013 o_coef_rd  out  1  coefficient ROM read strobe.
REQ-014 o_coef_addr  out  AW  coefficient block index.
REQ-015 i_coef  in  36*W  ROM data, valid the cycle after o_coef_rd.
REQ-016 o_pe_fea, o_pe_coef  out  36*W each  operands to the SVM PE.
REQ-017 o_pe_data  out  W  partial sum into the PE.
REQ-018 o_pe_valid  out  1  PE issue strobe.
REQ-019 i_pe_data  in  W  PE result (partial sum + dot product).
REQ-020 i_bias  in  W  SVM bias, sampled in ST_BIAS.
REQ-021 o_score  out  W  final score; o_detect out 1 (score >= 0); o_done out 1 (one-cycle pulse); o_busy out 1 (state != ST_IDLE).

Function
REQ-022 FSM states SHALL be ST_IDLE, ST_WAIT_FEA, ST_ISSUE, ST_WAIT_PE, ST_BIAS, ST_DONE.
REQ-023 ST_IDLE: on i_start go to ST_WAIT_FEA; clear blk_cnt and acc to 0.
REQ-024 o_fea_ready SHALL be 1 only in ST_WAIT_FEA; a transfer occurs when i_fea_valid && o_fea_ready.
REQ-025 On transfer: latch i_fea; in the same cycle assert o_coef_rd with o_coef_addr = blk_cnt; go to ST_ISSUE.
REQ-026 ST_ISSUE (one cycle): o_pe_valid = 1, o_pe_fea = latched features, o_pe_coef = i_coef, o_pe_data = acc; go to ST_WAIT_PE.
REQ-027 ST_WAIT_PE: count cycles; on the PE_LAT-th cycle after ST_ISSUE, capture acc <= i_pe_data.
REQ-028 After capture: if blk_cnt == NBLK-1 go to ST_BIAS; else increment blk_cnt and go to ST_WAIT_FEA.
REQ-029 Exactly one PE issue SHALL be outstanding at any time; o_pe_valid and o_coef_rd are 0 in all other cycles.
REQ-030 ST_BIAS: o_score <= acc + i_bias, computed at W+1 bits and saturated to [0x8000_0000, 0x7FFF_FFFF] (W=32); o_detect <= ~sum_sign; go to ST_DONE.
REQ-031 ST_DONE: o_done = 1 for one cycle; go to ST_IDLE.
REQ-032 o_score and o_detect SHALL hold until the next ST_BIAS.
REQ-033 Per-block latency from the accept cycle to acc capture SHALL be PE_LAT+1 cycles.
REQ-034 i_start SHALL be ignored when state != ST_IDLE.
REQ-035 i_abort in any non-idle state SHALL return to ST_IDLE next cycle: no o_done; o_score/o_detect unchanged; a PE result in flight is discarded. i_abort has priority over all other transitions.
REQ-036 i_fea_valid outside ST_WAIT_FEA SHALL have no effect.

Reset
REQ-037 While rst = 0: state = ST_IDLE; blk_cnt, acc, o_score, o_detect, o_done, o_pe_valid, o_coef_rd, o_fea_ready and the PE cycle counter = 0; o_coef_addr, o_pe_* operands = 0.
REQ-038 Reset asserted mid-window SHALL abandon the window; after release the block waits for a new i_start.

Verification
REQ-039 NBLK=4, PE model returns i_data+0x1000_0000, i_bias=0xC000_0000 -> o_coef_addr sequence 0,1,2,3; o_score=0x0000_0000, o_detect=1, single o_done pulse.
REQ-040 Same with i_bias=0xBFFF_FFFF -> o_score=0xFFFF_FFFF, o_detect=0.
REQ-041 NBLK=1, PE returns 0x7000_0000, i_bias=0x2000_0000 -> o_score=0x7FFF_FFFF (saturated), o_detect=1; PE returns 0x9000_0000, bias=0xE000_0000 -> 0x8000_0000, o_detect=0.
REQ-042 i_fea_valid held high throughout, PE_LAT=3 -> o_fea_ready high 1 cycle in every 5; o_pe_valid exactly NBLK times; o_pe_data of issue k = result of issue k-1 (0 for k=0).
REQ-043 i_abort in ST_WAIT_PE of block 2 -> ST_IDLE next cycle, no o_done, prior o_score kept; a new i_start then completes correctly with acc starting from 0.
REQ-044 rst=0 asserted mid-window, then i_start asserted during the window and again after completion -> all outputs 0 immediately; mid-window i_start ignored; post-completion i_start starts a new window.

Source files
------------

// File: rtl/svm_pe_ctrl.sv
// SVM processing-element controller: streams HOG feature blocks through a single
// external dot-product PE, chaining the partial sum across blocks, then adds the bias
// and produces a saturated score with a detect flag.
module svm_pe_ctrl #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 28,
    parameter int NBLK   = 105,
    parameter int PE_LAT = 3,
    // Clamp to one bit so a single-block window still has a legal address port.
    parameter int AW     = (NBLK > 1) ? $clog2(NBLK) : 1,
    localparam int W     = FEA_I + FEA_F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_fea_valid,
    output logic              o_fea_ready,
    input  logic [36*W-1:0]   i_fea,
    output logic              o_coef_rd,
    output logic [AW-1:0]     o_coef_addr,
    input  logic [36*W-1:0]   i_coef,
    output logic [36*W-1:0]   o_pe_fea,
    output logic [36*W-1:0]   o_pe_coef,
    output logic [W-1:0]      o_pe_data,
    output logic              o_pe_valid,
    input  logic [W-1:0]      i_pe_data,
    input  logic [W-1:0]      i_bias,
    output logic [W-1:0]      o_score,
    output logic              o_detect,
    output logic              o_done,
    output logic              o_busy
);

    localparam int CW = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FEA,
        ST_ISSUE,
        ST_WAIT_PE,
        ST_BIAS,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_blk_cnt;
    logic [CW-1:0]       r_pe_cnt;
    logic [W-1:0]        r_acc;
    logic [36*W-1:0]     r_fea;
    logic                r_fea_ready;
    logic                r_pe_valid;
    logic                r_done;
    logic [W-1:0]        r_score;
    logic                r_detect;

    logic                w_xfer;
    logic [W:0]          w_sum;
    logic [W-1:0]        w_sat;

    // Handshake; abort wins over a feature transfer in the same cycle.
    assign w_xfer = (r_state == ST_WAIT_FEA) && i_fea_valid && !i_abort;

    // Bias addition at W+1 bits with two's-complement saturation back to W bits.
    always_comb begin
        w_sum = {r_acc[W-1], r_acc} + {i_bias[W-1], i_bias};
        w_sat = w_sum[W-1:0];
        if (w_sum[W] != w_sum[W-1]) begin
            w_sat = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Main FSM with registered handshake, issue, done and score outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_blk_cnt   <= '0;
            r_pe_cnt    <= '0;
            r_acc       <= '0;
            r_fea       <= '0;
            r_fea_ready <= 1'b0;
            r_pe_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_score     <= '0;
            r_detect    <= 1'b0;
        end else begin
            r_pe_valid <= 1'b0;
            r_done     <= 1'b0;
            if (i_abort && (r_state != ST_IDLE)) begin
                // Any in-flight PE result is simply never captured.
                r_state     <= ST_IDLE;
                r_fea_ready <= 1'b0;
                r_pe_cnt    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state     <= ST_WAIT_FEA;
                            r_blk_cnt   <= '0;
                            r_acc       <= '0;
                            r_fea_ready <= 1'b1;
                        end
                    end
                    ST_WAIT_FEA: begin
                        if (i_fea_valid) begin
                            r_fea       <= i_fea;
                            r_fea_ready <= 1'b0;
                            r_pe_valid  <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        r_pe_cnt <= CW'(1);
                        r_state  <= ST_WAIT_PE;
                    end
                    ST_WAIT_PE: begin
                        if (r_pe_cnt == CW'(PE_LAT)) begin
                            r_acc    <= i_pe_data;
                            r_pe_cnt <= '0;
                            if (r_blk_cnt == AW'(NBLK - 1)) begin
                                r_state <= ST_BIAS;
                            end else begin
                                r_blk_cnt   <= r_blk_cnt + AW'(1);
                                r_fea_ready <= 1'b1;
                                r_state     <= ST_WAIT_FEA;
                            end
                        end else begin
                            r_pe_cnt <= r_pe_cnt + CW'(1);
                        end
                    end
                    ST_BIAS: begin
                        r_score  <= w_sat;
                        r_detect <= ~w_sum[W];
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_fea_ready = r_fea_ready;
    assign o_coef_rd   = w_xfer;
    assign o_coef_addr = r_blk_cnt;
    assign o_pe_valid  = r_pe_valid;
    assign o_pe_fea    = r_fea;
    // ROM data is only meaningful in the issue cycle; zero it elsewhere.
    assign o_pe_coef   = (r_state == ST_ISSUE) ? i_coef : '0;
    assign o_pe_data   = r_acc;
    assign o_score     = r_score;
    assign o_detect    = r_detect;
    assign o_done      = r_done;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_svm_pe_ctrl.sv
// Directed bench for svm_pe_ctrl: a 4-block instance with an incrementing PE model
// and a 1-block instance with a constant PE model for the saturation corners.
module tb_svm_pe_ctrl;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            fea_valid = 1'b0;
    logic [36*W-1:0] fea  = {36{32'hA5A5_0F0F}};
    logic [36*W-1:0] coef = {36{32'h0123_4567}};
    logic [W-1:0]    bias = '0;
    logic [W-1:0]    pe1_const = '0;

    logic            o0_fea_ready, o0_coef_rd, o0_pe_valid, o0_detect, o0_done, o0_busy;
    logic [1:0]      o0_coef_addr;
    logic [36*W-1:0] o0_pe_fea, o0_pe_coef;
    logic [W-1:0]    o0_pe_data, o0_score, pe0_in;

    logic            o1_fea_ready, o1_coef_rd, o1_pe_valid, o1_detect, o1_done, o1_busy;
    logic [0:0]      o1_coef_addr;
    logic [36*W-1:0] o1_pe_fea, o1_pe_coef;
    logic [W-1:0]    o1_pe_data, o1_score, pe1_in;

    svm_pe_ctrl #(.NBLK(4), .PE_LAT(LAT)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_fea_valid(fea_valid), .o_fea_ready(o0_fea_ready), .i_fea(fea),
        .o_coef_rd(o0_coef_rd), .o_coef_addr(o0_coef_addr), .i_coef(coef),
        .o_pe_fea(o0_pe_fea), .o_pe_coef(o0_pe_coef), .o_pe_data(o0_pe_data),
        .o_pe_valid(o0_pe_valid), .i_pe_data(pe0_in), .i_bias(bias),
        .o_score(o0_score), .o_detect(o0_detect), .o_done(o0_done), .o_busy(o0_busy)
    );

    svm_pe_ctrl #(.NBLK(1), .PE_LAT(LAT)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_fea_valid(fea_valid), .o_fea_ready(o1_fea_ready), .i_fea(fea),
        .o_coef_rd(o1_coef_rd), .o_coef_addr(o1_coef_addr), .i_coef(coef),
        .o_pe_fea(o1_pe_fea), .o_pe_coef(o1_pe_coef), .o_pe_data(o1_pe_data),
        .o_pe_valid(o1_pe_valid), .i_pe_data(pe1_in), .i_bias(bias),
        .o_score(o1_score), .o_detect(o1_detect), .o_done(o1_done), .o_busy(o1_busy)
    );

    // PE models: exact LAT-cycle pipelines, poisoned when no issue entered them.
    logic [W-1:0] pe0_q [0:LAT-1];
    logic [W-1:0] pe1_q [0:LAT-1];
    assign pe0_in = pe0_q[LAT-1];
    assign pe1_in = pe1_q[LAT-1];

    always @(posedge clk) begin
        pe0_q[0] <= o0_pe_valid ? o0_pe_data + 32'h1000_0000 : 32'hDEAD_BEEF;
        pe1_q[0] <= o1_pe_valid ? pe1_const : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) begin
            pe0_q[i] <= pe0_q[i-1];
            pe1_q[i] <= pe1_q[i-1];
        end
    end

    // Event logs for the 4-block instance, sampled on the falling edge.
    int cyc = 0, n_iss0 = 0, n_rd0 = 0, n_rdy0 = 0, n_done0 = 0, n_done1 = 0;
    int n_busy0 = 0, n_opbad = 0;
    logic [W-1:0] iss_data [64];
    int           rd_addr  [64];
    int           rdy_t    [64];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            if (o0_pe_valid) begin
                iss_data[n_iss0 % 64] = o0_pe_data;
                if (o0_pe_fea !== fea || o0_pe_coef !== coef) n_opbad = n_opbad + 1;
                n_iss0 = n_iss0 + 1;
            end
            if (o0_coef_rd) begin
                rd_addr[n_rd0 % 64] = int'(o0_coef_addr);
                n_rd0 = n_rd0 + 1;
            end
            if (o0_fea_ready) begin
                rdy_t[n_rdy0 % 64] = cyc;
                n_rdy0 = n_rdy0 + 1;
            end
            if (o0_done) n_done0 = n_done0 + 1;
            if (o1_done) n_done1 = n_done1 + 1;
            if (o0_busy) n_busy0 = n_busy0 + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((o0_busy || o1_busy) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (o0_busy || o1_busy) begin
            errors++;
            $display("FAIL wait_idle: busy0=%0b busy1=%0b, required both 0", o0_busy, o1_busy);
        end
    endtask

    task automatic wait_done0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (o0_done) ok = 1'b1;
        end
    endtask

    task automatic wait_done1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (o1_done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({o0_busy, o0_fea_ready, o0_pe_valid, o0_coef_rd, o0_done, o0_detect} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {o0_busy, o0_fea_ready, o0_pe_valid, o0_coef_rd, o0_done, o0_detect});
        end
        checks++;
        if (o0_score !== '0 || o0_pe_data !== '0 || o0_coef_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: score=%h pe_data=%h addr=%0d, required 0",
                     o0_score, o0_pe_data, o0_coef_addr);
        end
        checks++;
        if (o0_pe_fea !== '0 || o0_pe_coef !== '0) begin
            errors++;
            $display("FAIL reset_operands: nonzero PE operands, required 0");
        end
        rst = 1'b1;
        step();
        fea_valid = 1'b1;
    endtask

    // One full 4-block window with i_fea_valid held high.
    task automatic run_u0(input logic [W-1:0] b, input logic [W-1:0] exp_score,
                          input logic exp_det);
        int  b_iss, b_rd, b_rdy, b_done, b_busy;
        bit  ok;
        b_iss = n_iss0; b_rd = n_rd0; b_rdy = n_rdy0; b_done = n_done0; b_busy = n_busy0;
        bias = b;
        pulse_start();
        wait_done0(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL window_done: no o_done within budget, required a pulse");
        end
        checks++;
        if (o0_score !== exp_score || o0_detect !== exp_det) begin
            errors++;
            $display("FAIL window_score: score=%h detect=%b, required %h %b",
                     o0_score, o0_detect, exp_score, exp_det);
        end
        step();
        step();
        checks++;
        if (n_done0 - b_done != 1 || n_iss0 - b_iss != 4 || n_rd0 - b_rd != 4) begin
            errors++;
            $display("FAIL window_counts: done=%0d issues=%0d reads=%0d, required 1 4 4",
                     n_done0 - b_done, n_iss0 - b_iss, n_rd0 - b_rd);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_addr[(b_rd + k) % 64] != k) begin
                errors++;
                $display("FAIL coef_addr[%0d]: got %0d, required %0d", k,
                         rd_addr[(b_rd + k) % 64], k);
            end
            checks++;
            if (iss_data[(b_iss + k) % 64] !== W'(k) * 32'h1000_0000) begin
                errors++;
                $display("FAIL pe_data[%0d]: got %h, required %h", k,
                         iss_data[(b_iss + k) % 64], W'(k) * 32'h1000_0000);
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (rdy_t[(b_rdy + k) % 64] - rdy_t[(b_rdy + k - 1) % 64] != 5) begin
                errors++;
                $display("FAIL ready_spacing[%0d]: got %0d cycles, required 5", k,
                         rdy_t[(b_rdy + k) % 64] - rdy_t[(b_rdy + k - 1) % 64]);
            end
        end
        checks++;
        if (n_rdy0 - b_rdy != 4 || n_busy0 - b_busy != 22) begin
            errors++;
            $display("FAIL window_timing: ready=%0d busy=%0d, required 4 22",
                     n_rdy0 - b_rdy, n_busy0 - b_busy);
        end
        checks++;
        if (n_opbad != 0) begin
            errors++;
            $display("FAIL pe_operands: %0d bad issues, required 0", n_opbad);
        end
        wait_idle();
    endtask

    task automatic test_window();
        run_u0(32'hC000_0000, 32'h0000_0000, 1'b1);
        run_u0(32'hBFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic sat_case(input logic [W-1:0] pe, input logic [W-1:0] b,
                            input logic [W-1:0] exp_score, input logic exp_det);
        int b_done;
        bit ok;
        b_done = n_done1;
        pe1_const = pe;
        bias = b;
        pulse_start();
        wait_done1(ok);
        checks++;
        if (!ok || o1_score !== exp_score || o1_detect !== exp_det) begin
            errors++;
            $display("FAIL saturate: done=%b score=%h detect=%b, required 1 %h %b",
                     ok, o1_score, o1_detect, exp_score, exp_det);
        end
        step();
        checks++;
        if (n_done1 - b_done != 1) begin
            errors++;
            $display("FAIL saturate_done: %0d pulses, required 1", n_done1 - b_done);
        end
        wait_idle();
    endtask

    task automatic test_saturation();
        sat_case(32'h7000_0000, 32'h2000_0000, 32'h7FFF_FFFF, 1'b1);
        sat_case(32'h9000_0000, 32'hE000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_abort();
        logic [W-1:0] s_score;
        logic         s_det;
        int           b_iss, b_done, n;
        s_score = o0_score;
        s_det   = o0_detect;
        b_iss   = n_iss0;
        b_done  = n_done0;
        bias    = 32'hC000_0000;
        pulse_start();
        n = 0;
        while (n_iss0 - b_iss < 3 && n < 40) begin
            step();
            n++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (o0_busy !== 1'b0 || o0_pe_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b pe_valid=%b, required 0 0", o0_busy, o0_pe_valid);
        end
        repeat (10) step();
        checks++;
        if (n_done0 != b_done || n_iss0 - b_iss != 3) begin
            errors++;
            $display("FAIL abort_done: done=%0d issues=%0d, required 0 3",
                     n_done0 - b_done, n_iss0 - b_iss);
        end
        checks++;
        if (o0_score !== s_score || o0_detect !== s_det) begin
            errors++;
            $display("FAIL abort_hold: score=%h detect=%b, required %h %b",
                     o0_score, o0_detect, s_score, s_det);
        end
        wait_idle();
        run_u0(32'hBFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_reset_mid();
        int b_iss, b_done, n;
        bit ok;
        bias = 32'hC000_0000;
        b_iss = n_iss0;
        pulse_start();
        n = 0;
        while (n_iss0 - b_iss < 2 && n < 40) begin
            step();
            n++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({o0_busy, o0_fea_ready, o0_pe_valid, o0_coef_rd, o0_done, o0_detect} !== 6'b0 ||
            o0_score !== '0 || o0_pe_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: ctrl=%b score=%h pe_data=%h, required all 0",
                     {o0_busy, o0_fea_ready, o0_pe_valid, o0_coef_rd, o0_done, o0_detect},
                     o0_score, o0_pe_data);
        end
        step();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (o0_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait: busy=%b, required 0", o0_busy);
        end
        b_iss  = n_iss0;
        b_done = n_done0;
        pulse_start();
        repeat (8) step();
        pulse_start();
        wait_done0(ok);
        checks++;
        if (!ok || o0_score !== 32'h0 || o0_detect !== 1'b1) begin
            errors++;
            $display("FAIL restart_score: done=%b score=%h detect=%b, required 1 00000000 1",
                     ok, o0_score, o0_detect);
        end
        step();
        checks++;
        if (n_iss0 - b_iss != 4 || n_done0 - b_done != 1) begin
            errors++;
            $display("FAIL start_ignored: issues=%0d done=%0d, required 4 1",
                     n_iss0 - b_iss, n_done0 - b_done);
        end
        wait_idle();
        pulse_start();
        checks++;
        if (o0_busy !== 1'b1) begin
            errors++;
            $display("FAIL post_start: busy=%b, required 1", o0_busy);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_window();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
